regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (write_reg / write_data / reg_write) between two write-back requesters: the ALU result path and the memory load path.
- Keeps a 32-entry pending-write scoreboard so issue logic can stall on read-after-write hazards against reg1/reg2.
- Sits between the execute/memory stages and the register file. It drives the register-file write inputs directly.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/wb_scoreboard.sv | 56 +++++
 rtl/regfile_wb_arbiter.sv | 102 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package regfile_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // Starvation counter is 4 bits wide and saturates at its maximum.
  localparam logic [3:0] STARVE_MAX = 4'hF;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard with hazard detection and optional write-port bypass.
// Bypass compare is built only when REGFILE_WB_BYPASS_EN is defined.
module wb_scoreboard #(
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [ADDR_W-1:0] reg1,
  input  logic [ADDR_W-1:0] reg2,
  output logic              stall,
  output logic              fwd1_hit,
  output logic              fwd2_hit
);
  import regfile_pkg::*;

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0] pending_q, pending_d;
  logic             haz1, haz2;

  // Set is applied after clear so a newer outstanding writer keeps the bit.
  always_comb begin
    pending_d = pending_q;
    if (reg_write) begin
      pending_d[write_reg] = 1'b0;
    end
    if (iss_valid && (iss_rd != REG_ZERO)) begin
      pending_d[iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  assign fwd1_hit = reg_write && (write_reg == reg1) && (reg1 != REG_ZERO);
  assign fwd2_hit = reg_write && (write_reg == reg2) && (reg2 != REG_ZERO);
`else
  assign fwd1_hit = 1'b0;
  assign fwd2_hit = 1'b0;
`endif

  assign haz1  = pending_q[reg1] && (reg1 != REG_ZERO) && !fwd1_hit;
  assign haz2  = pending_q[reg2] && (reg2 != REG_ZERO) && !fwd2_hit;
  assign stall = !rst && (haz1 || haz2);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load write-backs onto the single register-file write port.
// Optional bypass forwarding is enabled by defining REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W       = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W       = regfile_pkg::ADDR_W,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic [ADDR_W-1:0] reg1,
  input  logic [ADDR_W-1:0] reg2,
  output logic              stall,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              reg_write
);
  import regfile_pkg::*;

  localparam logic [3:0] STARVE_LIM4 = 4'(STARVE_LIMIT);

  wb_req_t           alu_req, mem_req, win_req;
  logic              grant_alu, grant_mem;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              reg_write_q;
  logic [ADDR_W-1:0] write_reg_q;
  logic [DATA_W-1:0] write_data_q;

  // Load path has priority; the ALU wins once it has lost STARVE_LIMIT times in a row.
  always_comb begin
    alu_req   = '{valid: alu_valid, rd: alu_rd, data: alu_data};
    mem_req   = '{valid: mem_valid, rd: mem_rd, data: mem_data};
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!rst) begin
      if (alu_valid && (!mem_valid || (starve_cnt_q >= STARVE_LIM4))) begin
        grant_alu = 1'b1;
      end else if (mem_valid) begin
        grant_mem = 1'b1;
      end
    end
    win_req       = grant_alu ? alu_req : mem_req;
    win_req.valid = grant_alu || grant_mem;

    starve_cnt_d = starve_cnt_q;
    if (!alu_valid || grant_alu) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      reg_write_q  <= win_req.valid && (win_req.rd != REG_ZERO);
      if (win_req.valid) begin
        write_reg_q  <= win_req.rd;
        write_data_q <= win_req.data;
      end
    end
  end

  assign alu_ready  = grant_alu;
  assign mem_ready  = grant_mem;
  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;

  wb_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .reg_write(reg_write_q),
    .write_reg(write_reg_q),
    .reg1     (reg1),
    .reg2     (reg2),
    .stall    (stall),
    .fwd1_hit (fwd1_hit),
    .fwd2_hit (fwd2_hit)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (default STARVE_LIMIT=3).
module tb_regfile_wb_arbiter;

`ifdef REGFILE_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_rd, mem_rd, iss_rd, reg1, reg2, write_reg;
  logic [31:0] alu_data, mem_data, write_data;
  logic        iss_valid, stall, fwd1_hit, fwd2_hit, reg_write;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .reg1      (reg1),
    .reg2      (reg2),
    .stall     (stall),
    .fwd1_hit  (fwd1_hit),
    .fwd2_hit  (fwd2_hit),
    .write_reg (write_reg),
    .write_data(write_data),
    .reg_write (reg_write)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; alu_valid = 1'b1; mem_valid = 1'b1;
    alu_rd = 5'd6; alu_data = 32'h66; mem_rd = 5'd4; mem_data = 32'hA5A5; reg1 = 5'd4; reg2 = 5'd6;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL rst_alu_ready got %b want 0", alu_ready); end
      checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rst_mem_ready got %b want 0", mem_ready); end
      checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL rst_reg_write got %b want 0", reg_write); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stall); end
    end
    checks++; if (write_reg !== 5'd0) begin errors++; $display("FAIL rst_write_reg got %0d want 0", write_reg); end
    checks++; if (write_data !== 32'h0) begin errors++; $display("FAIL rst_write_data got %h want 0", write_data); end
    rst = 1'b0;
    #1;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL post_rst_mem_ready got %b want 1", mem_ready); end
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL post_rst_alu_ready got %b want 0", alu_ready); end
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL post_rst_reg_write got %b want 1", reg_write); end
    checks++; if (write_reg !== 5'd4) begin errors++; $display("FAIL post_rst_write_reg got %0d want 4", write_reg); end
    checks++; if (write_data !== 32'hA5A5) begin errors++; $display("FAIL post_rst_write_data got %h want a5a5", write_data); end
  endtask

  task automatic test_single;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_alu_ready got %b want 1", alu_ready); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL single_mem_ready got %b want 0", mem_ready); end
    tick();
    alu_valid = 1'b0;
    checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL single_reg_write got %b want 1", reg_write); end
    checks++; if (write_reg !== 5'd5) begin errors++; $display("FAIL single_write_reg got %0d want 5", write_reg); end
    checks++; if (write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_write_data got %h want deadbeef", write_data); end
    tick();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL single_idle_reg_write got %b want 0", reg_write); end
  endtask

  task automatic test_starvation;
    logic [7:0] exp_alu;
    exp_alu = 8'b1000_1000;  // bit i set: ALU wins in cycle i
    reg1 = 5'd0; reg2 = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h2;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (alu_ready !== exp_alu[i]) begin errors++; $display("FAIL starve_alu_ready[%0d] got %b want %b", i, alu_ready, exp_alu[i]); end
      checks++; if (mem_ready !== !exp_alu[i]) begin errors++; $display("FAIL starve_mem_ready[%0d] got %b want %b", i, mem_ready, !exp_alu[i]); end
      tick();
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    checks++; if (write_reg !== 5'd1) begin errors++; $display("FAIL starve_last_write_reg got %0d want 1", write_reg); end
    checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL starve_last_reg_write got %b want 1", reg_write); end
  endtask

  task automatic test_reg0;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h1234;
    #1;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL r0_mem_ready got %b want 1", mem_ready); end
    tick();
    mem_valid = 1'b0;
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL r0_reg_write got %b want 0", reg_write); end
    checks++; if (write_reg !== 5'd0) begin errors++; $display("FAIL r0_write_reg got %0d want 0", write_reg); end
    checks++; if (write_data !== 32'h1234) begin errors++; $display("FAIL r0_write_data got %h want 1234", write_data); end
    iss_valid = 1'b1; iss_rd = 5'd0;
    tick();
    iss_valid = 1'b0; reg1 = 5'd0; reg2 = 5'd0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall got %b want 0", stall); end
  endtask

  task automatic test_scoreboard;
    reg1 = 5'd0; reg2 = 5'd7; iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_pre_issue_stall got %b want 0", stall); end
    tick();
    iss_valid = 1'b0;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_pending_stall got %b want 1", stall); end
    tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_hold_stall got %b want 1", stall); end
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL sb_alu_ready got %b want 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    checks++; if (reg_write !== 1'b1 || write_reg !== 5'd7) begin errors++; $display("FAIL sb_wb got we=%b reg=%0d want we=1 reg=7", reg_write, write_reg); end
    checks++; if (stall !== !BYP) begin errors++; $display("FAIL sb_wb_stall got %b want %b", stall, !BYP); end
    checks++; if (fwd2_hit !== BYP) begin errors++; $display("FAIL sb_wb_fwd2 got %b want %b", fwd2_hit, BYP); end
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_cleared_stall got %b want 0", stall); end
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    iss_valid = 1'b0;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_reissue_stall got %b want 1", stall); end
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h78;
    tick();
    alu_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd7;  // re-issue in the clear cycle
    tick();
    iss_valid = 1'b0;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_set_wins_stall got %b want 1", stall); end
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL sb_set_wins_reg_write got %b want 0", reg_write); end
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h79;
    tick();
    alu_valid = 1'b0;
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_drain_stall got %b want 0", stall); end
    reg2 = 5'd0;
  endtask

  task automatic test_bypass;
    reg1 = 5'd9; reg2 = 5'd0; iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL byp_pending_stall got %b want 1", stall); end
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h9999;
    tick();
    mem_valid = 1'b0;
    checks++; if (write_data !== 32'h9999) begin errors++; $display("FAIL byp_write_data got %h want 9999", write_data); end
    checks++; if (fwd1_hit !== BYP) begin errors++; $display("FAIL byp_fwd1 got %b want %b", fwd1_hit, BYP); end
    checks++; if (fwd2_hit !== 1'b0) begin errors++; $display("FAIL byp_fwd2 got %b want 0", fwd2_hit); end
    checks++; if (stall !== !BYP) begin errors++; $display("FAIL byp_stall got %b want %b", stall, !BYP); end
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL byp_after_stall got %b want 0", stall); end
    reg1 = 5'd0;
  endtask

  task automatic test_back_to_back;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    tick();
    alu_valid = 1'b0; mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h44;
    checks++; if (reg_write !== 1'b1 || write_reg !== 5'd3) begin errors++; $display("FAIL b2b_first got we=%b reg=%0d want we=1 reg=3", reg_write, write_reg); end
    #1;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL b2b_mem_ready got %b want 1", mem_ready); end
    tick();
    mem_valid = 1'b0;
    checks++; if (reg_write !== 1'b1 || write_reg !== 5'd4) begin errors++; $display("FAIL b2b_second got we=%b reg=%0d want we=1 reg=4", reg_write, write_reg); end
    checks++; if (write_data !== 32'h44) begin errors++; $display("FAIL b2b_data got %h want 44", write_data); end
    tick();
  endtask

  task automatic test_mid_reset;
    iss_valid = 1'b1; iss_rd = 5'd11;
    tick();
    iss_valid = 1'b0; reg1 = 5'd11;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mrst_pending_stall got %b want 1", stall); end
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hAA; rst = 1'b1;
    #1;
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL mrst_alu_ready got %b want 0", alu_ready); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mrst_stall_in_rst got %b want 0", stall); end
    tick();
    rst = 1'b0; alu_valid = 1'b0;
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL mrst_reg_write got %b want 0", reg_write); end
    checks++; if (write_reg !== 5'd0 || write_data !== 32'h0) begin errors++; $display("FAIL mrst_outputs got reg=%0d data=%h want 0", write_reg, write_data); end
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mrst_pending_cleared got %b want 0", stall); end
    tick();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL mrst_no_replay got %b want 0", reg_write); end
    reg1 = 5'd0;
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0; iss_valid = 1'b0;
    alu_rd = '0; mem_rd = '0; iss_rd = '0; reg1 = '0; reg2 = '0;
    alu_data = '0; mem_data = '0;
    test_reset();
    test_single();
    test_starvation();
    test_reg0();
    test_scoreboard();
    test_bypass();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
